// File: rtl/nf_cc_ram_resp.sv
// Cross-connect RAM responder: single-ported word RAM with programmable wait states and a one-cycle ack.
// Optional NF_CC_RESP_RANGE_EN: out-of-range addresses suppress writes and read back 32'hDEAD_BEEF.
module nf_cc_ram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_cc,
  input  logic [31:0] wd_cc,
  input  logic        we_cc,
  input  logic        req_cc,
  output logic [31:0] rd_cc,
  output logic        req_ack_cc
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  localparam logic [3:0]  WS_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic        we_q;
  logic        ack_q;
  logic        rd_zero_q;
  logic        rd_oor_q;
  logic [31:0] mem_rd_q;

  logic [31:0] mem [2**ADDR_W];

  logic              start;
  logic              access;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wd;
  logic              acc_we;
  logic              acc_oor;
  logic [ADDR_W-1:0] acc_idx;

  // With zero wait states the access happens on the accepting edge, so it must use the live bus.
  assign start    = (state_q == ST_IDLE) && req_cc;
  assign access   = (start && (WAIT_STATES == 0)) || ((state_q == ST_WAIT) && (cnt_q == 4'd0));
  assign acc_addr = (state_q == ST_IDLE) ? addr_cc : addr_q;
  assign acc_wd   = (state_q == ST_IDLE) ? wd_cc   : wd_q;
  assign acc_we   = (state_q == ST_IDLE) ? we_cc   : we_q;
  assign acc_idx  = acc_addr[ADDR_W+1:2];

`ifdef NF_CC_RESP_RANGE_EN
  assign acc_oor = |acc_addr[31:ADDR_W+2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^acc_addr[1:0];
`else
  assign acc_oor = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:ADDR_W+2], acc_addr[1:0]};
`endif

  // Kept free of reset so it maps onto block RAM; reset only blocks a write landing on its edge.
  always_ff @(posedge clk) begin
    if (access && acc_we && !acc_oor && !reset) begin
      mem[acc_idx] <= acc_wd;
    end
    mem_rd_q <= mem[acc_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 32'd0;
      wd_q      <= 32'd0;
      we_q      <= 1'b0;
      ack_q     <= 1'b0;
      rd_zero_q <= 1'b0;
      rd_oor_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (start) begin
            addr_q <= addr_cc;
            wd_q   <= wd_cc;
            we_q   <= we_cc;
            if (WAIT_STATES == 0) begin
              state_q   <= ST_ACK;
              ack_q     <= 1'b1;
              rd_zero_q <= acc_we;
              rd_oor_q  <= acc_oor;
            end else begin
              cnt_q   <= WS_LOAD;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // req_cc is deliberately ignored here: an accepted transaction always completes.
          if (cnt_q == 4'd0) begin
            state_q   <= ST_ACK;
            ack_q     <= 1'b1;
            rd_zero_q <= acc_we;
            rd_oor_q  <= acc_oor;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack_cc = ack_q;
  assign rd_cc      = !ack_q    ? 32'd0    :
                      rd_zero_q ? 32'd0    :
                      rd_oor_q  ? OOR_DATA : mem_rd_q;

endmodule
